// File: rtl/dma_descriptor_sequencer.sv
// dma_descriptor_sequencer: queues DMA descriptors and programs the
// dma_engine CSR slave (regs 1..4, go, wait irq, read status) per entry.
module dma_descriptor_sequencer #(
   parameter int          WIDTHD     = 32,
   parameter int          FIFO_DEPTH = 4,
   parameter int unsigned GO_VALUE   = 1
) (
   input  logic                        clock,
   input  logic                        clock_areset_n,
   input  logic                        enable,
   input  logic                        d_valid,
   input  logic [4*WIDTHD-1:0]         d_data,
   output logic                        d_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [3:0]                  m_address,
   output logic [WIDTHD-1:0]           m_writedata,
   input  logic [WIDTHD-1:0]           m_readdata,
   output logic                        m_write,
   output logic                        m_read,
   input  logic                        m_waitrequest,
   input  logic                        m_readdatavalid,
   input  logic                        dma_irq,
   output logic                        busy,
   output logic                        done,
   output logic [WIDTHD-1:0]           done_status
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_GO,
      S_WAIT_IRQ,
      S_RD,
      S_RD_WAIT,
      S_DONE
   } state_t;

   state_t state;

   logic [4*WIDTHD-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [AW:0]         count;
   logic                push;
   logic                pop;

   logic [4*WIDTHD-1:0] desc;
   logic [2:0]          idx;

   assign d_ready    = (count != FULL);
   assign fifo_level = count;
   assign push       = d_valid && d_ready;
   assign pop        = (state == S_IDLE) && (count != '0) && enable;

   // descriptor storage; contents need no reset, the pointers gate use
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= d_data;
      end
   end

   // queue pointers and occupancy
   always_ff @(posedge clock or negedge clock_areset_n) begin
      if (!clock_areset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // per-descriptor CSR programming sequence with registered bus outputs
   always_ff @(posedge clock or negedge clock_areset_n) begin
      if (!clock_areset_n) begin
         state       <= S_IDLE;
         desc        <= '0;
         idx         <= '0;
         m_address   <= '0;
         m_writedata <= '0;
         m_write     <= 1'b0;
         m_read      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         done_status <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (pop) begin
                  desc        <= mem[rd_ptr];
                  idx         <= 3'd1;
                  m_address   <= 4'd1;
                  m_writedata <= mem[rd_ptr][WIDTHD-1:0];
                  m_write     <= 1'b1;
                  busy        <= 1'b1;
                  state       <= S_WR;
               end
            end
            S_WR: begin
               if (!m_waitrequest) begin
                  if (idx == 3'd4) begin
                     m_address   <= 4'd0;
                     m_writedata <= WIDTHD'(GO_VALUE);
                     state       <= S_GO;
                  end else begin
                     idx         <= idx + 3'd1;
                     m_address   <= {1'b0, idx + 3'd1};
                     m_writedata <= desc[2*WIDTHD-1:WIDTHD];
                     desc        <= desc >> WIDTHD;
                  end
               end
            end
            S_GO: begin
               if (!m_waitrequest) begin
                  m_write <= 1'b0;
                  state   <= S_WAIT_IRQ;
               end
            end
            S_WAIT_IRQ: begin
               if (dma_irq) begin
                  m_read    <= 1'b1;
                  m_address <= 4'd0;
                  state     <= S_RD;
               end
            end
            S_RD: begin
               if (!m_waitrequest) begin
                  m_read <= 1'b0;
                  if (m_readdatavalid) begin
                     done_status <= m_readdata;
                     done        <= 1'b1;
                     state       <= S_DONE;
                  end else begin
                     state <= S_RD_WAIT;
                  end
               end
            end
            S_RD_WAIT: begin
               if (m_readdatavalid) begin
                  done_status <= m_readdata;
                  done        <= 1'b1;
                  state       <= S_DONE;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_descriptor_sequencer.sv
// tb_dma_descriptor_sequencer: directed stimulus with a bus/status
// scoreboard checked by an independent monitor and a CSR slave model.
module tb_dma_descriptor_sequencer;

   localparam int W = 32;

   logic           clock = 1'b0;
   logic           clock_areset_n = 1'b1;
   logic           enable = 1'b1;
   logic           d_valid = 1'b0;
   logic [4*W-1:0] d_data = '0;
   logic           d_ready;
   logic [2:0]     fifo_level;
   logic [3:0]     m_address;
   logic [W-1:0]   m_writedata;
   logic [W-1:0]   m_readdata = '0;
   logic           m_write;
   logic           m_read;
   logic           m_waitrequest = 1'b0;
   logic           m_readdatavalid = 1'b0;
   logic           dma_irq = 1'b0;
   logic           busy;
   logic           done;
   logic [W-1:0]   done_status;

   dma_descriptor_sequencer #(
      .WIDTHD(W), .FIFO_DEPTH(4), .GO_VALUE(1)
   ) dut (
      .clock(clock),
      .clock_areset_n(clock_areset_n),
      .enable(enable),
      .d_valid(d_valid),
      .d_data(d_data),
      .d_ready(d_ready),
      .fifo_level(fifo_level),
      .m_address(m_address),
      .m_writedata(m_writedata),
      .m_readdata(m_readdata),
      .m_write(m_write),
      .m_read(m_read),
      .m_waitrequest(m_waitrequest),
      .m_readdatavalid(m_readdatavalid),
      .dma_irq(dma_irq),
      .busy(busy),
      .done(done),
      .done_status(done_status)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit           wr;
      logic [3:0]   addr;
      logic [W-1:0] data;
   } txn_t;

   txn_t         exp_bus[$];
   logic [W-1:0] exp_stat[$];
   txn_t         mt;

   int errors = 0;
   int checks = 0;
   int bus_txn = 0;
   int wr_txn = 0;
   int overlap = 0;
   int cyc = 0;
   int rdv_cyc = -10;
   bit stalled_prev = 0;
   logic [3:0]   prev_addr = '0;
   logic [W-1:0] prev_data = '0;

   int           stall_n = 0;
   int           rd_lat = 0;
   int           irq_delay = 3;
   bit           irq_auto = 1;
   logic [W-1:0] rd_value = '0;
   int           st_cnt = 0;
   int           pend = 0;
   int           irq_cnt = 0;

   task automatic check(input string name, input logic [W-1:0] act,
                        input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // CSR slave and dma_engine model, updated just after each edge
   always @(posedge clock) begin
      #1;
      if (!clock_areset_n) begin
         m_waitrequest   = 0;
         m_readdatavalid = 0;
         dma_irq         = 0;
         st_cnt          = 0;
         pend            = 0;
         irq_cnt         = 0;
      end else begin
         m_readdatavalid = 0;
         if (pend != 0) begin
            pend--;
            if (pend == 0) begin
               m_readdatavalid = 1;
               m_readdata      = rd_value;
            end
         end
         if (irq_cnt > 1) irq_cnt--;
         else if (irq_cnt == 1 && irq_auto) begin
            irq_cnt = 0;
            dma_irq = 1;
         end
         if (m_write || m_read) begin
            if (st_cnt < stall_n) begin
               m_waitrequest = 1;
               st_cnt++;
            end else begin
               m_waitrequest = 0;
               st_cnt = 0;
               if (m_read) begin
                  dma_irq = 0;
                  if (rd_lat == 0) begin
                     m_readdatavalid = 1;
                     m_readdata      = rd_value;
                  end else begin
                     pend = rd_lat;
                  end
               end
               if (m_write && m_address == 4'd0) irq_cnt = irq_delay;
            end
         end else begin
            m_waitrequest = 0;
            st_cnt = 0;
         end
      end
   end

   // monitor: pops expected bus transactions and status words
   always @(negedge clock) begin
      cyc++;
      if (!clock_areset_n) begin
         stalled_prev = 0;
      end else begin
         if (m_write && m_read) overlap++;
         if (stalled_prev) begin
            check("stall_addr", W'(m_address), W'(prev_addr));
            check("stall_data", m_writedata, prev_data);
         end
         stalled_prev = m_write && m_waitrequest;
         prev_addr    = m_address;
         prev_data    = m_writedata;
         if ((m_write || m_read) && !m_waitrequest) begin
            bus_txn++;
            if (m_write) wr_txn++;
            if (exp_bus.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_txn: addr=%0d wr=%0b", m_address, m_write);
            end else begin
               mt = exp_bus.pop_front();
               check("txn_kind", W'(m_write), W'(mt.wr));
               check("txn_addr", W'(m_address), W'(mt.addr));
               if (mt.wr) check("txn_data", m_writedata, mt.data);
            end
         end
         if (m_readdatavalid) rdv_cyc = cyc;
         if (done) begin
            check("done_latency", W'(cyc - rdv_cyc), 1);
            if (exp_stat.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: status=0x%0h", done_status);
            end else begin
               check("done_status", done_status, exp_stat.pop_front());
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic expect_desc(input logic [4*W-1:0] d, input logic [W-1:0] st);
      for (int i = 1; i <= 4; i++)
         exp_bus.push_back('{1'b1, 4'(i), d[(i-1)*W +: W]});
      exp_bus.push_back('{1'b1, 4'd0, 32'd1});
      exp_bus.push_back('{1'b0, 4'd0, 32'd0});
      exp_stat.push_back(st);
   endtask

   task automatic push(input logic [4*W-1:0] d, input logic [W-1:0] st,
                       output bit acc);
      d_valid = 1;
      d_data  = d;
      @(negedge clock);
      acc = d_ready;
      if (acc) expect_desc(d, st);
      @(posedge clock);
      #1;
      d_valid = 0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while ((exp_bus.size() != 0 || exp_stat.size() != 0 || busy) && n < budget) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s: timeout after %0d cycles, %0d txns pending", name, n, exp_bus.size());
      end
      tick(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int nacc;
      int snap;
      int n;

      #1 clock_areset_n = 0;
      #2;
      check("rst_busy", W'(busy), 0);
      check("rst_done", W'(done), 0);
      check("rst_write", W'(m_write), 0);
      check("rst_read", W'(m_read), 0);
      check("rst_ready", W'(d_ready), 1);
      check("rst_level", W'(fifo_level), 0);
      tick(2);
      clock_areset_n = 1;
      tick(2);

      stall_n = 0; rd_lat = 0; rd_value = 32'h3;
      push({32'h220, 32'h4, 32'h0800, 32'h1000}, 32'h3, acc);
      check("single_acc", W'(acc), 1);
      wait_idle(100, "single");
      check("status_held", done_status, 32'h3);

      stall_n = 3; rd_lat = 2; rd_value = 32'h55;
      snap = wr_txn;
      push({32'hA4, 32'hA3, 32'hA2, 32'hA1}, 32'h55, acc);
      wait_idle(300, "stall");
      check("stall_writes", W'(wr_txn - snap), 5);

      stall_n = 0; rd_lat = 1; rd_value = 32'h7; irq_auto = 0;
      nacc = 0;
      for (int i = 0; i < 6; i++) begin
         push({32'(i), 32'h30, 32'h20, 32'h100 + 32'(i)}, 32'h7, acc);
         if (acc) nacc++;
      end
      check("burst_accepted", W'(nacc), 5);
      check("burst_ready", W'(d_ready), 0);
      check("burst_level", W'(fifo_level), 4);
      check("burst_busy", W'(busy), 1);
      irq_auto = 1;
      wait_idle(800, "burst");
      check("drain_level", W'(fifo_level), 0);

      enable = 0;
      snap = bus_txn;
      push({32'hB4, 32'hB3, 32'hB2, 32'hB1}, 32'h7, acc);
      push({32'hC4, 32'hC3, 32'hC2, 32'hC1}, 32'h7, acc);
      tick(8);
      check("hold_bus", W'(bus_txn - snap), 0);
      check("hold_level", W'(fifo_level), 2);
      check("hold_busy", W'(busy), 0);
      enable = 1;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!m_write && n < 6);
      check("enable_latency", W'(n), 2);
      wait_idle(400, "enable");

      irq_auto = 0;
      snap = wr_txn;
      push({32'hD4, 32'hD3, 32'hD2, 32'hD1}, 32'h7, acc);
      push({32'hE4, 32'hE3, 32'hE2, 32'hE1}, 32'h7, acc);
      n = 0;
      while (wr_txn - snap < 5 && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("pre_reset_writes", W'(wr_txn - snap), 5);
      tick(3);
      #2 clock_areset_n = 0;
      #1;
      check("arst_busy", W'(busy), 0);
      check("arst_write", W'(m_write), 0);
      check("arst_read", W'(m_read), 0);
      check("arst_level", W'(fifo_level), 0);
      check("arst_ready", W'(d_ready), 1);
      exp_bus.delete();
      exp_stat.delete();
      tick(2);
      clock_areset_n = 1;
      irq_auto = 1;
      snap = bus_txn;
      tick(30);
      check("post_reset_bus", W'(bus_txn - snap), 0);
      check("post_reset_busy", W'(busy), 0);
      check("rw_overlap", W'(overlap), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
